// File: rtl/dota_sample_ctrl.sv
// Conversion sequencer for the digital OTA/comparator macro: auto-zero, settle,
// NSAMP comparator samples, majority vote. Optional SAR offset trim via OTA_OFFSET_CAL_EN.
module dota_sample_ctrl #(
    parameter int AZ_CYC     = 2,
    parameter int SETTLE_CYC = 4,
    parameter int NSAMP      = 8,
    parameter int TRIM_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp_out,
    output logic              cmp_en,
    output logic              cmp_az,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_bit,
    output logic [7:0]        res_count
`ifdef OTA_OFFSET_CAL_EN
    ,
    input  logic              cal_req,
    output logic [TRIM_W-1:0] trim
`endif
);
    // state    | meaning
    // IDLE     | waiting for start (or cal_req)
    // AUTOZERO | OTA enabled, inputs shorted
    // SETTLE   | OTA enabled, waiting out settling and synchronizer lag
    // SAMPLE   | accumulating synchronized comparator ones
    // DONE     | result presented until accepted
    // CAL      | SAR search of the offset trim code
    typedef enum logic [2:0] {
        S_IDLE, S_AZ, S_SETTLE, S_SAMPLE, S_DONE
`ifdef OTA_OFFSET_CAL_EN
        , S_CAL
`endif
    } state_t;

    localparam logic [9:0] AZ_LD     = 10'(AZ_CYC - 1);
    localparam logic [9:0] SETTLE_LD = 10'(SETTLE_CYC - 1);
    localparam logic [9:0] SAMP_LD   = 10'(NSAMP - 1);
    localparam logic [8:0] NSAMP_9   = 9'(NSAMP);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] ones_q, ones_d, ones_inc;
    logic       sync1_q, cs_q;
    logic       cmp_en_q, cmp_en_d, cmp_az_q, cmp_az_d, busy_q, busy_d;
    logic       res_valid_q, res_valid_d, res_bit_q, res_bit_d;
    logic [7:0] res_count_q, res_count_d;

`ifdef OTA_OFFSET_CAL_EN
    localparam logic [9:0]        CAL_LD     = 10'(AZ_CYC + SETTLE_CYC + NSAMP - 1);
    localparam logic [9:0]        NSAMP_10   = 10'(NSAMP);
    localparam logic [TRIM_W-1:0] TRIM_MID   = TRIM_W'(1) << (TRIM_W - 1);
    logic [TRIM_W-1:0] trim_q, trim_d, trim_save_q, trim_save_d, bit_mask;
    logic [7:0]        bit_q, bit_d;
    assign bit_mask = TRIM_W'(1) << bit_q;
    assign trim     = trim_q;
`endif

    assign ones_inc = ones_q + {7'd0, cs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ones_q      <= '0;
            sync1_q     <= 1'b0;
            cs_q        <= 1'b0;
            cmp_en_q    <= 1'b0;
            cmp_az_q    <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_bit_q   <= 1'b0;
            res_count_q <= '0;
`ifdef OTA_OFFSET_CAL_EN
            trim_q      <= TRIM_MID;
            trim_save_q <= TRIM_MID;
            bit_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            sync1_q     <= cmp_out;
            cs_q        <= sync1_q;
            cmp_en_q    <= cmp_en_d;
            cmp_az_q    <= cmp_az_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_bit_q   <= res_bit_d;
            res_count_q <= res_count_d;
`ifdef OTA_OFFSET_CAL_EN
            trim_q      <= trim_d;
            trim_save_q <= trim_save_d;
            bit_q       <= bit_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
`ifdef OTA_OFFSET_CAL_EN
        trim_d      = trim_q;
        trim_save_d = trim_save_q;
        bit_d       = bit_q;
`endif
        if (abort) begin
            state_d = S_IDLE;
            ones_d  = '0;
`ifdef OTA_OFFSET_CAL_EN
            if (state_q == S_CAL) trim_d = trim_save_q;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ones_d = '0;
                    cnt_d  = '0;
                    if (start) begin
                        state_d = S_AZ;
                        cnt_d   = AZ_LD;
                    end
`ifdef OTA_OFFSET_CAL_EN
                    else if (cal_req) begin
                        state_d     = S_CAL;
                        cnt_d       = CAL_LD;
                        bit_d       = 8'(TRIM_W - 1);
                        trim_save_d = trim_q;
                        trim_d      = TRIM_MID;
                    end
`endif
                end
                S_AZ: begin
                    if (cnt_q == '0) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_LD;
                    end else cnt_d = cnt_q - 10'd1;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_SAMPLE;
                        cnt_d   = SAMP_LD;
                    end else cnt_d = cnt_q - 10'd1;
                end
                S_SAMPLE: begin
                    ones_d = ones_inc;
                    if (cnt_q == '0) state_d = S_DONE;
                    else cnt_d = cnt_q - 10'd1;
                end
                S_DONE: if (res_ready) state_d = S_IDLE;
`ifdef OTA_OFFSET_CAL_EN
                // Each trim bit gets a full AZ+SETTLE+NSAMP window; only the last NSAMP cycles vote.
                S_CAL: begin
                    if (cnt_q < NSAMP_10) ones_d = ones_inc;
                    if (cnt_q == '0) begin
                        ones_d = '0;
                        if ({ones_inc, 1'b0} > NSAMP_9) trim_d = trim_q & ~bit_mask;
                        if (bit_q == '0) state_d = S_IDLE;
                        else begin
                            bit_d  = bit_q - 8'd1;
                            trim_d = trim_d | (bit_mask >> 1);
                            cnt_d  = CAL_LD;
                        end
                    end else cnt_d = cnt_q - 10'd1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state change.
    always_comb begin
        cmp_en_d    = 1'b0;
        cmp_az_d    = 1'b0;
        busy_d      = (state_d != S_IDLE);
        res_valid_d = 1'b0;
        res_bit_d   = 1'b0;
        res_count_d = '0;
        case (state_d)
            S_AZ: begin
                cmp_en_d = 1'b1;
                cmp_az_d = 1'b1;
            end
            S_SETTLE, S_SAMPLE: cmp_en_d = 1'b1;
            S_DONE: begin
                res_valid_d = 1'b1;
                if (state_q == S_DONE) begin
                    res_bit_d   = res_bit_q;
                    res_count_d = res_count_q;
                end else begin
                    res_bit_d   = ({ones_d, 1'b0} > NSAMP_9);
                    res_count_d = ones_d;
                end
            end
`ifdef OTA_OFFSET_CAL_EN
            S_CAL: begin
                cmp_en_d = 1'b1;
                cmp_az_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign cmp_en    = cmp_en_q;
    assign cmp_az    = cmp_az_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_bit   = res_bit_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_dota_sample_ctrl.sv
// Self-checking bench for dota_sample_ctrl: cycle-offset reference model plus directed
// and random stimulus. Define OTA_OFFSET_CAL_EN to exercise the calibration path.
module tb_dota_sample_ctrl;
    localparam int AZ   = 2;
    localparam int ST   = 4;
    localparam int NS   = 8;
    localparam int TW   = 4;
    localparam int LAT  = 1 + AZ + ST + NS;
    localparam int CALD = TW * (AZ + ST + NS);

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, abort = 1'b0, cmp_drv = 1'b0, res_ready = 1'b0;
    logic cmp_out;
    logic cmp_en, cmp_az, busy, res_valid, res_bit;
    logic [7:0] res_count;
`ifdef OTA_OFFSET_CAL_EN
    logic cal_req = 1'b0;
    logic cal_loop = 1'b0;
    logic [TW-1:0] trim;
    assign cmp_out = cal_loop ? (trim > 4'd5) : cmp_drv;
`else
    assign cmp_out = cmp_drv;
`endif

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    dota_sample_ctrl #(.AZ_CYC(AZ), .SETTLE_CYC(ST), .NSAMP(NS), .TRIM_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp_out(cmp_out),
        .cmp_en(cmp_en), .cmp_az(cmp_az), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_bit(res_bit), .res_count(res_count)
`ifdef OTA_OFFSET_CAL_EN
        , .cal_req(cal_req), .trim(trim)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the conversion by its start cycle and derives everything by offset.
    typedef enum {M_IDLE, M_CONV, M_DONE, M_CAL} mmode_t;
    mmode_t m_mode = M_IDLE;
    int n = 0;
    int t0 = 0;
    bit hist [0:19999];
    logic [7:0] m_count = 8'd0;
    logic m_bit = 1'b0;
    logic [3:0] m_trim = 4'd8;

    function automatic logic [3:0] sar_result();
        logic [3:0] t = 4'd0;
        for (int b = TW - 1; b >= 0; b--) begin
            t = t | (4'd1 << b);
            if (t > 4'd5) t = t & ~(4'd1 << b);
        end
        return t;
    endfunction

    always @(posedge clk) begin
        hist[n] = cmp_out;
        if (rst) begin
            m_mode = M_IDLE;
            m_trim = 4'd8;
            hist[n] = 1'b0;
            if (n > 0) hist[n-1] = 1'b0;
        end else if (abort) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start) begin m_mode = M_CONV; t0 = n; end
`ifdef OTA_OFFSET_CAL_EN
                    else if (cal_req) begin m_mode = M_CAL; t0 = n; end
`endif
                end
                M_CONV: if (n + 1 - t0 == LAT) begin
                    m_mode = M_DONE;
                    m_count = 8'd0;
                    for (int k = 0; k < NS; k++) m_count = m_count + 8'(hist[t0 + AZ + ST - 1 + k]);
                    m_bit = (2 * int'(m_count) > NS);
                end
                M_DONE: if (res_ready) m_mode = M_IDLE;
                M_CAL: if (n + 1 - t0 == CALD + 1) begin
                    m_mode = M_IDLE;
                    m_trim = sar_result();
                end
                default: m_mode = M_IDLE;
            endcase
        end
        n++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_en, e_az;
            e_en = (m_mode == M_CONV) || (m_mode == M_CAL);
            e_az = ((m_mode == M_CONV) && (n - t0 <= AZ)) || (m_mode == M_CAL);
            chk("cmp_en", 32'(cmp_en), 32'(e_en));
            chk("cmp_az", 32'(cmp_az), 32'(e_az));
            chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
            chk("res_valid", 32'(res_valid), 32'(m_mode == M_DONE));
            chk("res_bit", 32'(res_bit), (m_mode == M_DONE) ? 32'(m_bit) : 32'd0);
            chk("res_count", 32'(res_count), (m_mode == M_DONE) ? 32'(m_count) : 32'd0);
`ifdef OTA_OFFSET_CAL_EN
            if (m_mode != M_CAL) chk("trim", 32'(trim), 32'(m_trim));
`endif
        end
    end

    // Runs one conversion; pat[k] is cmp_out for the k-th sample window, offset for sync lag.
    task automatic run_pattern(input logic [7:0] pat, input int exp_cnt, input logic exp_bit);
        logic [7:0] p;
        p = pat;
        start = 1'b1;
        cmp_drv = 1'b0;
        for (int j = 1; j <= LAT; j++) begin
            @(negedge clk);
            start = 1'b0;
            cmp_drv = (j >= 5 && j < 13) ? p[j-5] : 1'b0;
        end
        chk("pat_valid", 32'(res_valid), 32'd1);
        chk("pat_count", 32'(res_count), 32'(exp_cnt));
        chk("pat_bit", 32'(res_bit), 32'(exp_bit));
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("accept_busy", 32'(busy), 32'd0);
        chk("accept_valid", 32'(res_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] az_bits, en_bits, va_bits;
        logic [7:0] held;
        logic saw_valid;
        repeat (3) @(negedge clk);
        chk("rst_cmp_en", 32'(cmp_en), 32'd0);
        chk("rst_cmp_az", 32'(cmp_az), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_count", 32'(res_count), 32'd0);
`ifdef OTA_OFFSET_CAL_EN
        chk("rst_trim", 32'(trim), 32'd8);
`endif
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Constant-one comparator: timing pattern pinned by literal bit vectors.
        az_bits = '0; en_bits = '0; va_bits = '0;
        start = 1'b1;
        cmp_drv = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            start = 1'b0;
            az_bits[j] = cmp_az;
            en_bits[j] = cmp_en;
            va_bits[j] = res_valid;
        end
        chk("az_cycles", 32'(az_bits), 32'h0006);
        chk("en_cycles", 32'(en_bits), 32'h7FFE);
        chk("valid_cycle", 32'(va_bits), 32'h8000);
        chk("ones_bit", 32'(res_bit), 32'd1);
        chk("ones_count", 32'(res_count), 32'd8);
        accept();

        run_pattern(8'b0101_0101, 4, 1'b0);
        accept();
        run_pattern(8'b0001_1111, 5, 1'b1);
        accept();
        run_pattern(8'b0000_0000, 0, 1'b0);
        accept();

        // Consumer stalls for 10 cycles.
        run_pattern(8'b1011_0110, 5, 1'b1);
        held = res_count;
        repeat (10) @(negedge clk);
        chk("stall_valid", 32'(res_valid), 32'd1);
        chk("stall_count", 32'(res_count), 32'(held));
        chk("stall_bit", 32'(res_bit), 32'd1);
        accept();

        // Stray starts during SETTLE and DONE are ignored.
        start = 1'b1; cmp_drv = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            start = (j == 4) || (j == 16);
            res_ready = (j == 18);
        end
        start = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        chk("stray_start_idle", 32'(busy), 32'd0);

        // Abort in cycle 9.
        start = 1'b1;
        saw_valid = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (j == 9);
            if (j == 10) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_en", 32'(cmp_en), 32'd0);
            end
            if (res_valid) saw_valid = 1'b1;
        end
        abort = 1'b0;
        chk("abort_no_result", 32'(saw_valid), 32'd0);

        // Reset during SAMPLE, then a clean conversion.
        start = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (j == 8);
        end
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_en", 32'(cmp_en), 32'd0);
        chk("rst_mid_count", 32'(res_count), 32'd0);
        @(negedge clk);
        run_pattern(8'b1110_0011, 5, 1'b1);
        accept();

`ifdef OTA_OFFSET_CAL_EN
        cal_loop = 1'b1;
        cal_req = 1'b1;
        for (int j = 1; j <= 22; j++) begin
            @(negedge clk);
            cal_req = 1'b0;
            abort = (j == 20);
        end
        abort = 1'b0;
        chk("cal_abort_trim", 32'(trim), 32'd8);
        chk("cal_abort_busy", 32'(busy), 32'd0);
        cal_req = 1'b1;
        for (int j = 1; j <= CALD + 2; j++) begin
            @(negedge clk);
            cal_req = 1'b0;
        end
        chk("cal_trim", 32'(trim), 32'd5);
        chk("cal_busy", 32'(busy), 32'd0);
        chk("cal_no_result", 32'(res_valid), 32'd0);
        cal_loop = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cmp_drv   = 1'($urandom);
            start     = ($urandom % 8) == 0;
            abort     = ($urandom % 64) == 0;
            res_ready = ($urandom % 3) == 0;
            rst       = ($urandom % 200) == 0;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; res_ready = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
